// File: rtl/bus_bridge_target.sv
// Bus-to-UART bridge target: serialises tagged read/write request frames onto a byte
// transmitter and matches tagged read responses, with read timeout, bounded retry and error completion.
module bus_bridge_target #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 12,
    parameter int                    TIMEOUT_CYCLES = 65535,
    parameter int                    MAX_RETRY      = 2,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = '1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  mem_wen,
    input  logic                  mem_ren,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_rvalid,
    output logic                  rd_err,
    output logic                  bridge_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_busy,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid
);
    localparam int PB  = (ADDR_WIDTH + DATA_WIDTH + 7) / 8;
    localparam int RB  = (DATA_WIDTH + 7) / 8;
    localparam int PW  = PB * 8;
    localparam int RW  = RB * 8;
    localparam int BIW = $clog2(PB + 2);
    localparam int RIW = $clog2(RB + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP, RESP_WAIT} state_t;

    state_t                  state;
    logic [6:0]              tag;
    logic [6:0]              out_tag;
    logic                    mode;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [BIW-1:0]          byte_idx;
    logic                    guard;
    logic [TW-1:0]           tmo_cnt;
    logic [2:0]              retry_cnt;
    logic [RIW-1:0]          rx_idx;
    logic [6:0]              rx_tag;
    logic [RW-1:0]           rx_buf;

    logic [PW-1:0]           payload;
    logic [7:0]              tx_byte;
    logic [RW-1:0]           rx_asm;
    logic                    resp_done;
    logic                    resp_match;
    logic                    tmo_expire;

    // Request side: mem_wen/mem_ren are accepted only in a cycle with bridge_ready=1 and
    // are ignored otherwise; mem_rvalid is a single-cycle completion with no backpressure.
    assign bridge_ready = (state == IDLE);

    always_comb begin
        payload    = PW'({addr_q, wdata_q});
        tx_byte    = (byte_idx == '0) ? {mode, tag}
                                      : 8'(payload >> (8 * (PB - int'(byte_idx))));
        rx_asm     = (rx_buf << 8) | RW'(rx_data);
        resp_done  = rx_valid && (rx_idx == RIW'(RB));
        resp_match = resp_done && (state == RESP_WAIT) && (rx_tag == out_tag);
        tmo_expire = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    end

    // Response deserializer runs regardless of FSM state so stale frames are consumed whole.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_idx <= '0;
            rx_tag <= '0;
            rx_buf <= '0;
        end else if (rx_valid) begin
            if (rx_idx == '0) begin
                if (rx_data[7]) begin
                    rx_tag <= rx_data[6:0];
                    rx_buf <= '0;
                    rx_idx <= RIW'(1);
                end
            end else if (resp_done) begin
                rx_idx <= '0;
            end else begin
                rx_buf <= rx_asm;
                rx_idx <= rx_idx + RIW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            tag        <= '0;
            out_tag    <= '0;
            mode       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            byte_idx   <= '0;
            guard      <= 1'b0;
            tmo_cnt    <= '0;
            retry_cnt  <= '0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            mem_rdata  <= '0;
            mem_rvalid <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            tx_start   <= 1'b0;
            mem_rvalid <= 1'b0;
            rd_err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_wen || mem_ren) begin
                        mode     <= mem_wen;
                        addr_q   <= mem_addr;
                        wdata_q  <= mem_wen ? mem_wdata : '0;
                        byte_idx <= '0;
                        if (!mem_wen) retry_cnt <= '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= tx_byte;
                        byte_idx <= byte_idx + BIW'(1);
                        guard    <= 1'b1;
                        state    <= GAP;
                        if (byte_idx == '0) begin
                            out_tag <= tag;
                            tag     <= tag + 7'd1;
                        end
                    end
                end
                GAP: begin
                    // The guard cycle covers the one-cycle lag before tx_busy rises.
                    if (guard) begin
                        guard <= 1'b0;
                    end else if (!tx_busy) begin
                        if (byte_idx != BIW'(PB + 1)) begin
                            state <= SEND;
                        end else if (mode) begin
                            state <= IDLE;
                        end else begin
                            tmo_cnt <= '0;
                            state   <= RESP_WAIT;
                        end
                    end
                end
                RESP_WAIT: begin
                    if (resp_match) begin
                        mem_rdata  <= rx_asm[DATA_WIDTH-1:0];
                        mem_rvalid <= 1'b1;
                        state      <= IDLE;
                    end else if (tmo_expire) begin
                        if (retry_cnt < 3'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + 3'd1;
                            byte_idx  <= '0;
                            state     <= SEND;
                        end else begin
                            mem_rdata  <= ERR_DATA;
                            mem_rvalid <= 1'b1;
                            rd_err     <= 1'b1;
                            state      <= IDLE;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_bridge_target.sv
// Bench for bus_bridge_target: directed and random bus requests, a transmitter busy model,
// a response driver, and a frame/completion reference model built from the protocol rules.
module tb_bus_bridge_target;
    localparam int DW   = 8;
    localparam int AW   = 12;
    localparam int T    = 20;
    localparam int MR   = 2;
    localparam int BUSY = 10;
    localparam int PB   = (AW + DW + 7) / 8;
    localparam int FB   = 1 + PB;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          mem_wen = 1'b0, mem_ren = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic [DW-1:0] mem_rdata;
    logic          mem_rvalid, rd_err, bridge_ready;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;

    bus_bridge_target #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T), .MAX_RETRY(MR), .ERR_DATA('1)
    ) dut (
        .clk(clk), .rstn(rstn), .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .rd_err(rd_err),
        .bridge_ready(bridge_ready), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_valid(rx_valid)
    );

    // Clock, cycle counter and transmitter busy model
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int busy_cnt = 0;
    always @(posedge clk) begin
        if (tx_start) busy_cnt <= BUSY;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard state
    logic [7:0] exp_q[$];
    logic [7:0] cap_q[$];
    int         cap_cyc[$];
    logic [7:0] rv_data_q[$];
    logic       rv_err_q[$];
    int         rv_cyc_q[$];
    logic [6:0] model_tag = '0;
    logic       prev_start = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            prev_start = 1'b0;
        end else begin
            if (tx_start) begin
                checks++;
                assert (tx_busy === 1'b0) else begin
                    errors++;
                    $error("FAIL tx_start_while_busy: observed tx_busy=%0b expected 0", tx_busy);
                end
                checks++;
                assert (prev_start === 1'b0) else begin
                    errors++;
                    $error("FAIL tx_start_back_to_back: observed previous tx_start=%0b expected 0", prev_start);
                end
                cap_q.push_back(tx_data);
                cap_cyc.push_back(cyc);
            end
            if (rd_err) begin
                checks++;
                assert (mem_rvalid === 1'b1) else begin
                    errors++;
                    $error("FAIL rd_err_alone: observed mem_rvalid=%0b expected 1", mem_rvalid);
                end
            end
            if (mem_rvalid) begin
                rv_data_q.push_back(mem_rdata);
                rv_err_q.push_back(rd_err);
                rv_cyc_q.push_back(cyc);
            end
            prev_start = tx_start;
        end
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference model: one frame = header {mode, tag} then {addr, data} MSB byte first.
    task automatic push_frame(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [31:0] p;
        p = (32'(a) << DW) | 32'(d);
        exp_q.push_back({wr, model_tag});
        for (int i = PB - 1; i >= 0; i--) exp_q.push_back(8'((p >> (8 * i)) & 32'hFF));
        model_tag = model_tag + 7'd1;
    endtask

    task automatic take_frame(input string name, output int sf, output int sl);
        int budget;
        logic [7:0] got, want;
        budget = 2000;
        while (cap_q.size() < FB && budget > 0) begin
            tick();
            budget--;
        end
        check({name, "_arrive"}, 32'(cap_q.size() >= FB), 1);
        sf = 0;
        sl = 0;
        for (int i = 0; i < FB; i++) begin
            if (cap_q.size() > 0 && exp_q.size() > 0) begin
                if (i == 0) sf = cap_cyc[0];
                sl   = cap_cyc.pop_front();
                got  = cap_q.pop_front();
                want = exp_q.pop_front();
                check(name, got, want);
            end
        end
        exp_q.delete();
    endtask

    task automatic clear_all();
        cap_q.delete(); cap_cyc.delete(); exp_q.delete();
        rv_data_q.delete(); rv_err_q.delete(); rv_cyc_q.delete();
        model_tag = '0;
    endtask

    task automatic do_req(input logic wen, input logic ren, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int k);
        int budget;
        budget = 500;
        while (!bridge_ready && budget > 0) begin
            tick();
            budget--;
        end
        check("req_ready", bridge_ready, 1);
        mem_wen = wen; mem_ren = ren; mem_addr = a; mem_wdata = d;
        k = cyc;
        tick();
        mem_wen = 1'b0; mem_ren = 1'b0;
        mem_addr = AW'($urandom); mem_wdata = DW'($urandom);
    endtask

    task automatic drive_byte(input logic [7:0] b, output int m);
        rx_data = b; rx_valid = 1'b1;
        m = cyc;
        tick();
        rx_valid = 1'b0; rx_data = 8'($urandom);
        tick();
    endtask

    task automatic wait_rv(input string name, input logic [DW-1:0] d, input logic e, input int at);
        int budget;
        budget = 1000;
        while (rv_data_q.size() == 0 && budget > 0) begin
            tick();
            budget--;
        end
        check({name, "_arrive"}, 32'(rv_data_q.size() > 0), 1);
        if (rv_data_q.size() > 0) begin
            check({name, "_data"}, rv_data_q.pop_front(), d);
            check({name, "_err"}, rv_err_q.pop_front(), e);
            check({name, "_cycle"}, rv_cyc_q.pop_front(), at);
        end
        tick();
        check({name, "_ready_after"}, bridge_ready, 1);
        tick();
        check({name, "_single_pulse"}, rv_data_q.size(), 0);
    endtask

    task automatic run_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic both,
                             input bit chk_lat);
        int k, sf, sl, budget;
        do_req(1'b1, both, a, d, k);
        push_frame(1'b1, a, d);
        take_frame("wr_frame", sf, sl);
        if (chk_lat) check("wr_latency", sf, k + 2);
        budget = 200;
        while (!bridge_ready && budget > 0) begin
            tick();
            budget--;
        end
        check("wr_idle_cycle", cyc, sl + BUSY + 2);
        check("wr_no_rvalid", rv_data_q.size(), 0);
    endtask

    // kind: 0 clean response, 1 stale tag first, 2 junk byte first, 3 no response, 4 expiry tie
    task automatic run_read(input logic [AW-1:0] a, input int kind, input logic [DW-1:0] rd,
                            input bit chk_lat);
        int k, sf, sl, m, x;
        logic [6:0] t;
        do_req(1'b0, 1'b1, a, DW'($urandom), k);
        t = model_tag;
        push_frame(1'b0, a, '0);
        take_frame("rd_frame", sf, sl);
        if (chk_lat) check("rd_latency", sf, k + 2);
        if (kind == 3) begin
            for (int r = 0; r < MR; r++) begin
                x = sl + BUSY + 2 + T;
                push_frame(1'b0, a, '0);
                take_frame("retry_frame", sf, sl);
                check("retry_time", sf, x + 1);
            end
            wait_rv("rd_fail", '1, 1'b1, sl + BUSY + 2 + T);
        end else if (kind == 4) begin
            x = sl + BUSY + 2 + T;
            while (cyc < x - 3) tick();
            drive_byte({1'b1, t}, m);
            drive_byte(rd, m);
            wait_rv("rd_tie", rd, 1'b0, x);
            repeat (30) tick();
            check("tie_no_retry", cap_q.size(), 0);
        end else begin
            while (cyc < sl + BUSY + 4) tick();
            if (kind == 1) begin
                drive_byte({1'b1, t + 7'd5}, m);
                drive_byte(~rd, m);
            end
            if (kind == 2) drive_byte({1'b0, 7'($urandom)}, m);
            drive_byte({1'b1, t}, m);
            drive_byte(rd, m);
            wait_rv("rd_resp", rd, 1'b0, m + 1);
        end
    endtask

    initial begin
        int k;
        int budget;
        repeat (3) tick();
        check("rst_bridge_ready", bridge_ready, 1);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_mem_rvalid", mem_rvalid, 0);
        check("rst_rd_err", rd_err, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        rstn = 1'b1;
        tick();

        run_write(12'h123, 8'hA5, 1'b0, 1'b1);

        rstn = 1'b0;
        tick();
        clear_all();
        rstn = 1'b1;
        tick();

        run_read(12'h0F0, 0, 8'h3C, 1'b1);
        run_read(AW'($urandom), 1, DW'($urandom), 1'b1);
        run_read(AW'($urandom), 3, '0, 1'b1);
        run_read(AW'($urandom), 4, DW'($urandom), 1'b1);
        run_read(AW'($urandom), 2, DW'($urandom), 1'b1);

        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 1)
                run_write(AW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            else
                run_read(AW'($urandom), int'($urandom_range(0, 4)), DW'($urandom), 1'b1);
        end

        do_req(1'b1, 1'b0, 12'h456, 8'h5A, k);
        budget = 500;
        while (cap_q.size() < 3 && budget > 0) begin
            tick();
            budget--;
        end
        check("mid_tx_start_before", tx_start, 1);
        rstn = 1'b0;
        #1;
        check("mid_rst_tx_start", tx_start, 0);
        check("mid_rst_ready", bridge_ready, 1);
        clear_all();
        tick();
        tick();
        rstn = 1'b1;
        tick();
        run_write(12'h456, 8'h5A, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
